// File: rtl/spi_event_sync_pkg.sv
// Shared types and helpers for the SPI clock-domain event synchroniser.
package spi_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE  = 2'b00,
    EDGE_FALL  = 2'b01,
    EDGE_BOTH  = 2'b10,
    EDGE_LEVEL = 2'b11
  } edge_mode_t;

  // Upper bound on channel count so the mode vector can be passed at a fixed width.
  localparam int unsigned MaxCh = 32;

  function automatic edge_mode_t edge_mode(input logic [2*MaxCh-1:0] modes,
                                           input int unsigned ch);
    return edge_mode_t'(modes[2*ch +: 2]);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned len);
    return (len == 0) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/spi_event_sync_chan.sv
// One synchroniser channel: inversion, flop chain, stability filter, edge detect
// and optional sticky pending/overflow tracking.
module spi_sync_chan
  import spi_sync_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH = 2,
  parameter int unsigned FILTER_LEN = 0,
  parameter edge_mode_t  MODE       = EDGE_RISE,
  parameter bit          INVERT     = 1'b0,
  parameter bit          STICKY     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic asyncIn,
  input  logic ack,
  input  logic ovfClear,
  output logic syncLevel,
  output logic evtPulse,
  output logic evtPending,
  output logic evtOverflow,
  output logic pendingNext
);

  localparam int unsigned     CntW   = cnt_width(FILTER_LEN);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN);

  logic [SYNC_DEPTH-1:0] chainQ;
  logic [CntW-1:0]       cntQ, cntD;
  logic                  inX, chainOut, mismatch, accept;
  logic                  levelD, pulseD, pendD, ovfD;

  always_comb begin
    inX      = asyncIn ^ INVERT;
    chainOut = chainQ[SYNC_DEPTH-1];
    mismatch = (chainOut != syncLevel);
    accept   = mismatch && (cntQ == CntMax);
    levelD   = accept ? chainOut : syncLevel;

    cntD = cntQ;
    if (!mismatch || accept) begin
      cntD = '0;
    end else if (cntQ < CntMax) begin
      cntD = cntQ + 1'b1;
    end

    pulseD = 1'b0;
    unique case (MODE)
      EDGE_RISE:  pulseD = accept && chainOut;
      EDGE_FALL:  pulseD = accept && !chainOut;
      EDGE_BOTH:  pulseD = accept;
      EDGE_LEVEL: pulseD = 1'b0;
    endcase

    pendD = 1'b0;
    ovfD  = 1'b0;
    if (STICKY) begin
      // A new event beats a simultaneous ack; overflow beats a simultaneous clear.
      if (pulseD) begin
        pendD = 1'b1;
      end else if (ack) begin
        pendD = 1'b0;
      end else begin
        pendD = evtPending;
      end

      if (pulseD && evtPending && !ack) begin
        ovfD = 1'b1;
      end else if (ovfClear) begin
        ovfD = 1'b0;
      end else begin
        ovfD = evtOverflow;
      end
    end
    pendingNext = pendD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chainQ      <= '0;
      cntQ        <= '0;
      syncLevel   <= 1'b0;
      evtPulse    <= 1'b0;
      evtPending  <= 1'b0;
      evtOverflow <= 1'b0;
    end else begin
      chainQ      <= {chainQ[SYNC_DEPTH-2:0], inX};
      cntQ        <= cntD;
      syncLevel   <= levelD;
      evtPulse    <= pulseD;
      evtPending  <= pendD;
      evtOverflow <= ovfD;
    end
  end

endmodule

// File: rtl/spi_event_sync.sv
// Multi-channel sclk-to-clk event synchroniser for the SPI slave register interface.
module spi_event_sync
  import spi_sync_pkg::*;
#(
  parameter int unsigned         N_CH       = 4,
  parameter int unsigned         SYNC_DEPTH = 2,
  parameter int unsigned         FILTER_LEN = 0,
  parameter logic [2*N_CH-1:0]   EDGE_MODE  = '0,
  parameter logic [N_CH-1:0]     INVERT     = '0,
  parameter logic [N_CH-1:0]     STICKY     = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_level,
  output logic [N_CH-1:0] evt_pulse,
  output logic [N_CH-1:0] evt_pending,
  input  logic [N_CH-1:0] evt_ack,
  output logic [N_CH-1:0] evt_overflow,
  input  logic            ovf_clear,
  output logic            any_pending
);

  if (SYNC_DEPTH < 2) begin : gen_bad_depth
    $error("spi_event_sync: SYNC_DEPTH must be at least 2");
  end
  if (N_CH < 1 || N_CH > MaxCh) begin : gen_bad_nch
    $error("spi_event_sync: N_CH out of range");
  end

  localparam logic [2*MaxCh-1:0] ModeExt = (2*MaxCh)'(EDGE_MODE);

  logic [N_CH-1:0] pendNext;

  for (genvar i = 0; i < N_CH; i++) begin : gen_chan
    spi_sync_chan #(
      .SYNC_DEPTH(SYNC_DEPTH),
      .FILTER_LEN(FILTER_LEN),
      .MODE      (edge_mode(ModeExt, i)),
      .INVERT    (INVERT[i]),
      .STICKY    (STICKY[i])
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .asyncIn    (async_in[i]),
      .ack        (evt_ack[i]),
      .ovfClear   (ovf_clear),
      .syncLevel  (sync_level[i]),
      .evtPulse   (evt_pulse[i]),
      .evtPending (evt_pending[i]),
      .evtOverflow(evt_overflow[i]),
      .pendingNext(pendNext[i])
    );
  end

  // Built from next-state pending so it lines up with evt_pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_pending <= 1'b0;
    end else begin
      any_pending <= |pendNext;
    end
  end

endmodule

// File: tb/tb_spi_event_sync.sv
// Scoreboard bench: a 4-channel unfiltered instance and a 1-channel filtered instance.
module tb_spi_event_sync;

  localparam logic [3:0] InvA = 4'b0100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ain = '0, ackA = '0;
  logic       ovfClrA = 1'b0;
  logic [3:0] levA, pulA, pendA, ovfA;
  logic       anyA;
  logic       bin = 1'b0, ackB = 1'b0, ovfClrB = 1'b0;
  logic       levB, pulB, pendB, ovfB, anyB;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  bit          monEn = 1'b0;

  typedef struct {
    int unsigned at;
    logic [3:0]  mask;
  } exp_t;
  exp_t qA[$];
  exp_t qB[$];

  always #5 clk = ~clk;

  spi_event_sync #(
    .N_CH      (4),
    .SYNC_DEPTH(2),
    .FILTER_LEN(0),
    .EDGE_MODE (8'b11_10_01_00),
    .INVERT    (InvA),
    .STICKY    (4'b0001)
  ) dutA (
    .clk         (clk),
    .reset       (reset),
    .async_in    (ain),
    .sync_level  (levA),
    .evt_pulse   (pulA),
    .evt_pending (pendA),
    .evt_ack     (ackA),
    .evt_overflow(ovfA),
    .ovf_clear   (ovfClrA),
    .any_pending (anyA)
  );

  spi_event_sync #(
    .N_CH      (1),
    .SYNC_DEPTH(2),
    .FILTER_LEN(3),
    .EDGE_MODE (2'b00),
    .INVERT    (1'b0),
    .STICKY    (1'b0)
  ) dutB (
    .clk         (clk),
    .reset       (reset),
    .async_in    (bin),
    .sync_level  (levB),
    .evt_pulse   (pulB),
    .evt_pending (pendB),
    .evt_ack     (ackB),
    .evt_overflow(ovfB),
    .ovf_clear   (ovfClrB),
    .any_pending (anyB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected event per channel for a settled level change oldX -> newX.
  function automatic logic [3:0] evMaskA(input logic [3:0] oldX, input logic [3:0] newX);
    logic [3:0] r, f;
    r = ~oldX & newX;
    f = oldX & ~newX;
    return {1'b0, r[2] | f[2], f[1], r[0]};
  endfunction

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setA(input logic [3:0] v);
    logic [3:0] m;
    m = evMaskA(ain ^ InvA, v ^ InvA);
    if (m != 4'b0) qA.push_back('{at: cyc + 3, mask: m});
    ain = v;
  endtask

  // Pulse monitor: compares every cycle against the scoreboard, sampled 1 after the edge.
  always @(posedge clk) begin
    logic [3:0] expA, expB;
    exp_t       e;
    cyc = cyc + 1;
    #1;
    if (monEn) begin
      expA = '0;
      expB = '0;
      while (qA.size() > 0 && qA[0].at <= cyc) begin
        e = qA.pop_front();
        if (e.at == cyc) expA |= e.mask;
      end
      while (qB.size() > 0 && qB[0].at <= cyc) begin
        e = qB.pop_front();
        if (e.at == cyc) expB |= e.mask;
      end
      checkVal("pulseA", 32'(pulA), 32'(expA));
      checkVal("pulseB", 32'(pulB), 32'(expB[0]));
    end
  end

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_levA"}, 32'(levA), 32'h0);
    checkVal({tag, "_pulA"}, 32'(pulA), 32'h0);
    checkVal({tag, "_pendA"}, 32'(pendA), 32'h0);
    checkVal({tag, "_ovfA"}, 32'(ovfA), 32'h0);
    checkVal({tag, "_anyA"}, 32'(anyA), 32'h0);
    checkVal({tag, "_levB"}, 32'(levB), 32'h0);
    checkVal({tag, "_pulB"}, 32'(pulB), 32'h0);
  endtask

  initial begin
    waitNeg(2);
    checkAllZero("rst");

    // ch2 is inverted, so its idle-low input reads as 1 after release.
    reset = 1'b0;
    monEn = 1'b1;
    qA.push_back('{at: cyc + 3, mask: evMaskA(4'b0000, ain ^ InvA)});
    waitNeg(5);
    checkVal("levA_idle", 32'(levA), 32'h4);

    // All channels toggle together; pulses only where the mode matches.
    setA(4'b1111);
    waitNeg(5);
    checkVal("levA_high", 32'(levA), 32'hB);
    checkVal("pendA_1", 32'(pendA), 32'h1);
    checkVal("anyA_1", 32'(anyA), 32'h1);
    setA(4'b0000);
    waitNeg(5);
    checkVal("levA_low", 32'(levA), 32'h4);
    checkVal("pendA_keep", 32'(pendA), 32'h1);
    ackA = 4'b1111;
    waitNeg(1);
    ackA = 4'b0000;
    checkVal("pendA_ack", 32'(pendA), 32'h0);
    checkVal("anyA_ack", 32'(anyA), 32'h0);
    checkVal("ovfA_none", 32'(ovfA), 32'h0);

    // Two unacknowledged events on the sticky channel.
    setA(4'b0001);
    waitNeg(5);
    setA(4'b0000);
    waitNeg(5);
    setA(4'b0001);
    waitNeg(5);
    checkVal("pendA_2ev", 32'(pendA), 32'h1);
    checkVal("ovfA_2ev", 32'(ovfA), 32'h1);
    ackA = 4'b0001;
    waitNeg(1);
    ackA = 4'b0000;
    checkVal("pendA_ack2", 32'(pendA), 32'h0);
    checkVal("ovfA_hold", 32'(ovfA), 32'h1);
    ovfClrA = 1'b1;
    waitNeg(1);
    ovfClrA = 1'b0;
    checkVal("ovfA_clr", 32'(ovfA), 32'h0);

    // Event coincident with ack while pending: event wins, no overflow.
    setA(4'b0000);
    waitNeg(5);
    setA(4'b0001);
    waitNeg(5);
    checkVal("pendA_pre", 32'(pendA), 32'h1);
    setA(4'b0000);
    waitNeg(5);
    setA(4'b0001);
    waitNeg(2);
    ackA = 4'b0001;
    waitNeg(1);
    ackA = 4'b0000;
    checkVal("pendA_evack", 32'(pendA), 32'h1);
    checkVal("ovfA_evack", 32'(ovfA), 32'h0);
    checkVal("anyA_evack", 32'(anyA), 32'h1);

    // New overflow coincident with ovf_clear: overflow wins.
    setA(4'b0000);
    waitNeg(5);
    setA(4'b0001);
    waitNeg(2);
    ovfClrA = 1'b1;
    waitNeg(1);
    ovfClrA = 1'b0;
    checkVal("ovfA_win", 32'(ovfA), 32'h1);

    // Filtered channel: short glitch rejected, long pulse accepted 6 edges in.
    bin = 1'b1;
    waitNeg(2);
    bin = 1'b0;
    waitNeg(10);
    checkVal("levB_glitch", 32'(levB), 32'h0);
    qB.push_back('{at: cyc + 6, mask: 4'b0001});
    bin = 1'b1;
    waitNeg(7);
    checkVal("levB_high", 32'(levB), 32'h1);
    waitNeg(3);
    bin = 1'b0;
    waitNeg(12);
    checkVal("levB_low", 32'(levB), 32'h0);

    // Reset mid-chain clears everything at once.
    setA(4'b1111);
    bin = 1'b1;
    waitNeg(1);
    monEn = 1'b0;
    reset = 1'b1;
    #1;
    checkAllZero("midrst");
    qA.delete();
    qB.delete();
    waitNeg(2);
    reset = 1'b0;
    monEn = 1'b1;
    qA.push_back('{at: cyc + 3, mask: evMaskA(4'b0000, ain ^ InvA)});
    qB.push_back('{at: cyc + 6, mask: 4'b0001});
    waitNeg(8);
    checkVal("levA_post", 32'(levA), 32'hB);
    checkVal("pendA_post", 32'(pendA), 32'h1);
    checkVal("levB_post", 32'(levB), 32'h1);
    checkVal("ovfA_post", 32'(ovfA), 32'h0);

    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_event_sync.md
Name: spi_event_sync

Overview:
- Parametrised multi-channel clock-domain synchroniser for the SPI slave.
- Each channel takes one single-bit signal from the sclk domain (ssel, load/ready strobes) and brings it into the clk domain.
- Per channel it applies an optional input inversion, a SYNC_DEPTH flop chain, an optional stability filter and configurable edge detection.
- Events can optionally be held as sticky pending flags with acknowledge and overflow detection. The block sits between the sclk-domain shifter and the clk-domain register interface.

Parameters:
- N_CH, 4, number of channels (>= 1).
- SYNC_DEPTH, 2, flops in each synchroniser chain (>= 2). Elaboration error if < 2.
- FILTER_LEN, 0, extra consecutive clk cycles a new level must persist before it is accepted. 0 = no filter.
- EDGE_MODE, all zero, 2*N_CH bits, 2 bits per channel: 00 rising, 01 falling, 10 both, 11 level only (no events).
- INVERT, all zero, N_CH-bit mask; set bit inverts that input before synchronisation (use for active-low ssel).
- STICKY, all zero, N_CH-bit mask; set bit enables the pending/ack/overflow logic for that channel.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- async_in  in  N_CH  asynchronous inputs from the sclk domain
- sync_level  out  N_CH  filtered, synchronised level (after inversion)
- evt_pulse  out  N_CH  one-cycle event strobe per channel
- evt_pending  out  N_CH  sticky event flag (STICKY channels only)
- evt_ack  in  N_CH  clears evt_pending, clk domain
- evt_overflow  out  N_CH  event arrived while pending was still set
- ovf_clear  in  1  clears all evt_overflow bits
- any_pending  out  1  OR of evt_pending

Behaviour:
- Reset is asynchronous. All flops clear to 0: chain, filter counter, sync_level, evt_pulse, evt_pending, evt_overflow, any_pending.
- Input x = async_in[i] ^ INVERT[i]. The chain is s[0..SYNC_DEPTH-1] with s[0] <= x.
- Mismatch m = (s[SYNC_DEPTH-1] != sync_level[i]).
- Filter counter cnt has width max(1, clog2(FILTER_LEN+1)).
  - cnt increments while m is true and cnt < FILTER_LEN.
  - cnt clears whenever m is false.
- accept = m && (cnt == FILTER_LEN). With FILTER_LEN = 0, accept = m.
- On accept: sync_level <= s[SYNC_DEPTH-1], cnt <= 0.
- evt_pulse[i] is registered. It is set in the same cycle as the accept and is high for exactly one clk cycle.
  - Mode 00: only on a 0->1 accept.
  - Mode 01: only on a 1->0 accept.
  - Mode 10: on either.
  - Mode 11: never.
- Latency from x stable before clk edge 1 to sync_level and evt_pulse: SYNC_DEPTH+1+FILTER_LEN edges.
- Glitch rejection: a level seen at s[SYNC_DEPTH-1] for fewer than FILTER_LEN+1 consecutive cycles is discarded and produces no event.
- Sticky channels, evaluated at each clk edge when evt_pulse is being set:
  - event and pending=0: pending <= 1.
  - event and pending=1 and ack=0: pending stays 1, overflow <= 1.
  - event and ack in the same cycle: pending stays 1, no overflow (the new event wins).
  - ack without event: pending <= 0. Ack while pending is 0 is ignored.
- evt_overflow holds until ovf_clear. ovf_clear in the same cycle as a new overflow: the overflow wins, bit stays 1.
- Non-sticky channels: evt_pending = 0 and evt_overflow = 0 permanently. evt_ack for those channels is ignored.
- any_pending is registered as the OR of the next-state pending bits, so it is coincident with evt_pending.
- Reset mid-operation: all state is lost. If x = 1 after reset release, a rising accept (and event, per mode) occurs SYNC_DEPTH+1+FILTER_LEN edges later. INVERT exists so that idle-high inputs such as ssel see 0 when idle.
- Channels are fully independent; simultaneous events on several channels are all reported.

Decomposition:
- Package spi_sync_pkg holds:
  - typedef enum logic [1:0] edge_mode_t {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_LEVEL};
  - function edge_mode(EDGE_MODE, i) that extracts one channel's field;
  - the counter-width function.
- Sub-module spi_sync_chan implements one channel: chain, filter, edge detect, sticky logic.
- The top generates N_CH instances and ORs any_pending.

Test Plan:
- N_CH=1, D=2, L=0, mode 00: async_in 0->1 before edge 1 -> sync_level=1 and evt_pulse=1 for one cycle after edge 3; 1->0 -> no pulse.
- Mode 10, INVERT=1: async_in 1->0 -> sync_level 0->1 with a pulse after edge 3; async_in 0->1 -> second pulse after 3 edges.
- L=3: a 2-cycle high glitch -> no level change and no pulse; a 10-cycle high -> pulse exactly 6 edges after the start.
- STICKY=1: two events with no ack -> pending=1, overflow=1; ack -> pending=0, overflow stays 1; ovf_clear -> overflow=0.
- STICKY=1: event in the same cycle as ack with pending=1 -> pending stays 1, overflow stays 0.
- N_CH=4, modes {00,01,10,11}: toggle all inputs together -> pulses only on the channels whose mode matches; channel 3 produces none. Reset asserted mid-chain -> all outputs 0 immediately.
